// File: rtl/sdx_kernel_addwm_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sdx_kernel_addwm_read_scheduler
// Purpose  : Splits a kernel read request (start address, length in beats)
//            into AXI4 AR bursts. No burst exceeds C_BURST_LEN beats or
//            crosses a 4 KB boundary. Issued-but-incomplete bursts are
//            counted and capped at C_MAX_OUTSTANDING.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            ctrl_start/addr/length - request from the kernel control FSM
//            ctrl_idle, ctrl_done   - status back to the control FSM
//            m_axi_ar*             - AXI4 read address channel (master side)
//            rlast_hs              - one pulse per completed read burst
//            outstanding           - current outstanding burst count
// Revision : 1.0 - initial release
// ============================================================================
module sdx_kernel_addwm_read_scheduler #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_LENGTH_WIDTH    = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]                    ctrl_addr,
    input  logic [C_LENGTH_WIDTH-1:0]                  ctrl_length,
    output logic                                       ctrl_idle,
    output logic                                       ctrl_done,
    output logic                                       m_axi_arvalid,
    input  logic                                       m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]                    m_axi_araddr,
    output logic [7:0]                                 m_axi_arlen,
    input  logic                                       rlast_hs,
    output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0]     outstanding
);

    localparam int OUT_W      = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int BEAT_BYTES = C_DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_LENGTH_WIDTH-1:0] remaining_q, remaining_d;
    logic [8:0]                len_q, len_d;
    logic                      arvalid_q, arvalid_d;
    logic [C_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]                arlen_q, arlen_d;
    logic                      idle_q, idle_d;
    logic                      done_q, done_d;
    logic [OUT_W-1:0]          outstanding_q, outstanding_d;

    logic                      w_ar_hs;
    logic                      w_rlast;
    logic                      w_slot_free;
    logic [12:0]               w_bnd_beats;
    logic [12:0]               w_cap;
    logic [8:0]                w_len;

    assign w_ar_hs     = arvalid_q & m_axi_arready;
    // A completion with nothing outstanding is dropped so the count cannot wrap.
    assign w_rlast     = rlast_hs & (outstanding_q != '0);
    assign w_slot_free = outstanding_q < OUT_W'(C_MAX_OUTSTANDING);

    // Beats left before the next 4 KB page; 13 bits so a page-aligned
    // address yields the full 4096 bytes.
    assign w_bnd_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> BEAT_SHIFT;
    assign w_cap       = (w_bnd_beats < 13'(C_BURST_LEN)) ? w_bnd_beats : 13'(C_BURST_LEN);
    assign w_len       = (remaining_q < C_LENGTH_WIDTH'(w_cap)) ? remaining_q[8:0] : w_cap[8:0];

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            len_q         <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            idle_q        <= 1'b1;
            done_q        <= 1'b0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            len_q         <= len_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            idle_q        <= idle_d;
            done_q        <= done_d;
            outstanding_q <= outstanding_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ctrl_start) state_d = S_CALC;
            S_CALC:  state_d = (remaining_q == '0) ? S_DRAIN : S_ISSUE;
            S_ISSUE: if (w_ar_hs) state_d = S_CALC;
            S_DRAIN: if (outstanding_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        arvalid_d   = 1'b0;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    addr_d      = ctrl_addr;
                    remaining_d = ctrl_length;
                end
            end
            S_CALC: begin
                if (remaining_q != '0) begin
                    len_d     = w_len;
                    araddr_d  = addr_q;
                    arlen_d   = 8'(w_len - 9'd1);
                    arvalid_d = w_slot_free;
                end
            end
            S_ISSUE: begin
                if (w_ar_hs) begin
                    addr_d      = addr_q + (C_ADDR_WIDTH'(len_q) << BEAT_SHIFT);
                    remaining_d = remaining_q - C_LENGTH_WIDTH'(len_q);
                end else begin
                    // Once raised, arvalid holds until accepted; the slot
                    // gate only decides when it is first raised.
                    arvalid_d = arvalid_q | w_slot_free;
                end
            end
            default: ;
        endcase

        idle_d = (state_d == S_IDLE);
        done_d = (state_d == S_DONE);

        outstanding_d = outstanding_q;
        if (w_ar_hs && !w_rlast) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!w_ar_hs && w_rlast) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    assign ctrl_idle     = idle_q;
    assign ctrl_done     = done_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign outstanding   = outstanding_q;

endmodule
`default_nettype wire
